accum_drain: RTL and testbench

- Drain stage directly downstream of the accumulator table (accumTable).
- On `start`, reads a block of `num_rows` consecutive accumulator rows, all columns in parallel. Each row is streamed out as one wide word over a valid/ready interface to the output writeback buffer.
- Issues `clear` to the table once the block has been fully drained, so the next tile accumulates from 0.
- Absorbs the table's 1-cycle read latency and downstream backpressure with a 2-entry output FIFO and credit-based read issue.

---
 rtl/accum_drain_if.sv | 18 +
 rtl/accum_drain.sv | 205 ++++++++++++++++++++
 tb/tb_accum_drain.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_drain_if.sv
// accum_drain_if: valid/ready output stream carrying one accumulator row per word.
//   out_valid : word available (driven by master)
//   out_ready : sink accepts the word (driven by slave)
//   out_data  : one accumulator row, lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_row   : row index of out_data within the drained block
interface accum_drain_if #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned SYS_ARR_COLS = 16,
   parameter int unsigned CNT_W        = 11
);
   logic                               out_valid;
   logic                               out_ready;
   logic [DATA_WIDTH*SYS_ARR_COLS-1:0] out_data;
   logic [CNT_W-1:0]                   out_row;

   modport master (output out_valid, output out_data, output out_row, input out_ready);
   modport slave  (input out_valid, input out_data, input out_row, output out_ready);
endinterface

// File: rtl/accum_drain.sv
// accum_drain: drains a block of consecutive accumulator-table rows into a
// valid/ready stream, then clears the table.
//
// Reads are issued against a credit of 2 (FIFO occupancy plus the read in
// flight, less the word leaving this cycle), so the 1-cycle table read
// latency and downstream stalls are absorbed by a 2-entry fall-through FIFO
// without ever overflowing it.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : drain request, honoured only when idle
//   base_addr     : first table row of the block (sampled on start)
//   num_rows      : rows in the block, 0 allowed (sampled on start)
//   busy, done    : drain in progress / one-cycle completion pulse
//   acc_rd_en     : table read enable, replicated per column
//   acc_rd_addr   : table read address, replicated per column slice
//   acc_rd_data   : table read data, valid one cycle after acc_rd_en
//   acc_clear     : table clear, replicated per column
//   out_if        : output row stream (accum_drain_if.master)
//
// Build option: define ACCUM_DRAIN_RELU_EN to zero negative lanes on entry
// to the FIFO; otherwise data passes bit-exact.
module accum_drain #(
   parameter  int unsigned DATA_WIDTH     = 16,
   parameter  int unsigned MAX_OUT_ROWS   = 128,
   parameter  int unsigned MAX_OUT_COLS   = 128,
   parameter  int unsigned SYS_ARR_COLS   = 16,
   localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
   localparam int unsigned ADDR_W         = $clog2(NUM_ACCUM_ROWS),
   localparam int unsigned CNT_W          = $clog2(NUM_ACCUM_ROWS + 1),
   localparam int unsigned WORD_W         = DATA_WIDTH * SYS_ARR_COLS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          base_addr,
   input  logic [CNT_W-1:0]           num_rows,
   output logic                       busy,
   output logic                       done,
   output logic [SYS_ARR_COLS-1:0]    acc_rd_en,
   output logic [ADDR_W*SYS_ARR_COLS-1:0] acc_rd_addr,
   input  logic [WORD_W-1:0]          acc_rd_data,
   output logic [SYS_ARR_COLS-1:0]    acc_clear,
   accum_drain_if.master              out_if
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_CLEAR = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_num_rows;
   logic [CNT_W-1:0]  r_issued;
   logic              r_inflight;
   logic [CNT_W-1:0]  r_inflight_row;

   // FIFO as a 2-deep shift register: entry 0 is always the head
   logic              r_valid0;
   logic              r_valid1;
   logic [WORD_W-1:0] r_data0;
   logic [WORD_W-1:0] r_data1;
   logic [CNT_W-1:0]  r_row0;
   logic [CNT_W-1:0]  r_row1;

   logic [2:0]        w_state_nxt;
   logic              w_load;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic [1:0]        w_occ;
   logic              w_credit_ok;
   logic [WORD_W-1:0] w_wdata;

   assign w_push      = r_inflight;
   assign w_pop       = r_valid0 && out_if.out_ready;
   // Slots committed once this cycle's transfer (if any) has left
   assign w_occ       = 2'(r_valid0) + 2'(r_valid1) + 2'(r_inflight) - 2'(w_pop);
   assign w_credit_ok = (w_occ < 2'd2);

   // Optional ReLU on the write path; no added latency
`ifdef ACCUM_DRAIN_RELU_EN
   always_comb begin
      w_wdata = acc_rd_data;
      for (int unsigned c = 0; c < SYS_ARR_COLS; c++) begin
         if (acc_rd_data[c*DATA_WIDTH + DATA_WIDTH - 1]) begin
            w_wdata[c*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   end
`else
   assign w_wdata = acc_rd_data;
`endif

   // Next-state and read-issue decision
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = (num_rows != '0) ? S_READ : S_CLEAR;
            end
         end
         S_READ: begin
            if ((r_issued < r_num_rows) && w_credit_ok) begin
               w_issue = 1'b1;
               if ((r_issued + CNT_W'(1)) == r_num_rows) begin
                  w_state_nxt = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (!r_valid0 && !r_inflight) begin
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, issue counters and FIFO
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_addr         <= '0;
         r_num_rows     <= '0;
         r_issued       <= '0;
         r_inflight     <= 1'b0;
         r_inflight_row <= '0;
         r_valid0       <= 1'b0;
         r_valid1       <= 1'b0;
         r_data0        <= '0;
         r_data1        <= '0;
         r_row0         <= '0;
         r_row1         <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_issue;

         if (w_load) begin
            r_addr     <= base_addr;
            r_num_rows <= num_rows;
            r_issued   <= '0;
         end else if (w_issue) begin
            r_issued       <= r_issued + CNT_W'(1);
            r_inflight_row <= r_issued;
            r_addr         <= (r_addr == ADDR_W'(NUM_ACCUM_ROWS - 1)) ? '0 : r_addr + ADDR_W'(1);
         end

         case ({w_push, w_pop})
            2'b10: begin
               if (!r_valid0) begin
                  r_valid0 <= 1'b1;
                  r_data0  <= w_wdata;
                  r_row0   <= r_inflight_row;
               end else begin
                  r_valid1 <= 1'b1;
                  r_data1  <= w_wdata;
                  r_row1   <= r_inflight_row;
               end
            end
            2'b01: begin
               r_valid0 <= r_valid1;
               r_valid1 <= 1'b0;
               r_data0  <= r_data1;
               r_row0   <= r_row1;
            end
            2'b11: begin
               // Occupancy unchanged; new word lands behind whatever remains
               if (r_valid1) begin
                  r_data0 <= r_data1;
                  r_row0  <= r_row1;
                  r_data1 <= w_wdata;
                  r_row1  <= r_inflight_row;
               end else begin
                  r_data0 <= w_wdata;
                  r_row0  <= r_inflight_row;
               end
            end
            default: ;
         endcase
      end
   end

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(w_push && r_valid1 && !w_pop));

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign acc_clear   = {SYS_ARR_COLS{r_state == S_CLEAR}};
   assign acc_rd_en   = {SYS_ARR_COLS{w_issue}};
   assign acc_rd_addr = w_issue ? {SYS_ARR_COLS{r_addr}} : '0;

   assign out_if.out_valid = r_valid0;
   assign out_if.out_data  = r_data0;
   assign out_if.out_row   = r_row0;

endmodule

// File: tb/tb_accum_drain.sv
// tb_accum_drain: scoreboard bench for accum_drain with a behavioural
// accumulator table (1-cycle registered read).
module tb_accum_drain;
   localparam int unsigned DW     = 16;
   localparam int unsigned C      = 16;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned CNT_W  = 11;
   localparam int unsigned W      = DW * C;
   localparam int          NROWS  = 1024;

`ifdef ACCUM_DRAIN_RELU_EN
   localparam logic [15:0] EXP_NEG = 16'h0000;
`else
   localparam logic [15:0] EXP_NEG = 16'h8005;
`endif

   typedef struct packed {
      logic [CNT_W-1:0] row;
      logic [W-1:0]     data;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic [CNT_W-1:0]    num_rows;
   logic                busy;
   logic                done;
   logic [C-1:0]        acc_rd_en;
   logic [ADDR_W*C-1:0] acc_rd_addr;
   logic [W-1:0]        acc_rd_data;
   logic [C-1:0]        acc_clear;

   accum_drain_if #(.DATA_WIDTH(DW), .SYS_ARR_COLS(C), .CNT_W(CNT_W)) out_if ();

   accum_drain #(
      .DATA_WIDTH(DW), .MAX_OUT_ROWS(128), .MAX_OUT_COLS(128), .SYS_ARR_COLS(C)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_rows(num_rows), .busy(busy), .done(done), .acc_rd_en(acc_rd_en),
      .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
      .acc_clear(acc_clear), .out_if(out_if)
   );

   always #5 clk = ~clk;

   exp_t       exp_q[$];
   int         addr_q[$];
   int         acc_cyc[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rd_cnt, clr_cnt, clr_cyc, done_cyc, first_valid;
   logic [W-1:0]     last_data;
   logic             p_stall;
   logic [W-1:0]     p_data;
   logic [CNT_W-1:0] p_row;
   int               mon_a;
   exp_t             mon_e;

   // Table contents: lane c of row a is a*16+c, except row 5 carries a
   // negative lane 0 and a small positive lane 1.
   function automatic logic [W-1:0] row_val(input int a);
      logic [W-1:0] v;
      for (int c = 0; c < int'(C); c++) v[c*DW +: DW] = 16'(a * 16 + c);
      if (a == 5) begin
         v[15:0]  = 16'h8005;
         v[31:16] = 16'h0007;
      end
      return v;
   endfunction

   function automatic logic [W-1:0] exp_val(input int a);
      logic [W-1:0] v;
      v = row_val(a);
`ifdef ACCUM_DRAIN_RELU_EN
      for (int c = 0; c < int'(C); c++) if (v[c*DW + DW - 1]) v[c*DW +: DW] = '0;
`endif
      return v;
   endfunction

   task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Table model: registered read
   always @(posedge clk) acc_rd_data <= acc_rd_en[0] ? row_val(int'(acc_rd_addr[ADDR_W-1:0])) : '0;

   // Monitor: read addresses, clears, stall stability, scoreboard pops
   always @(negedge clk) begin
      if (reset) begin
         p_stall = 1'b0;
      end else begin
         if (acc_rd_en != '0) begin
            rd_cnt++;
            chk("rd_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) begin
               mon_a = addr_q.pop_front();
               chk("rd_addr", acc_rd_addr, {C{ADDR_W'(mon_a)}});
            end
            chk("rd_en_all", acc_rd_en, {C{1'b1}});
         end
         if (acc_clear != '0) begin
            clr_cnt++;
            clr_cyc = cyc;
            chk("clear_all", acc_clear, {C{1'b1}});
         end
         if (done) done_cyc = cyc;
         if (out_if.out_valid && first_valid < 0) first_valid = cyc;
         if (p_stall) begin
            chk("stall_valid", out_if.out_valid, 1);
            chk("stall_data", out_if.out_data, p_data);
            chk("stall_row", out_if.out_row, p_row);
         end
         p_stall = out_if.out_valid && !out_if.out_ready;
         p_data  = out_if.out_data;
         p_row   = out_if.out_row;
         if (out_if.out_valid && out_if.out_ready) begin
            acc_cyc.push_back(cyc);
            last_data = out_if.out_data;
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("out_row", out_if.out_row, mon_e.row);
               chk("out_data", out_if.out_data, mon_e.data);
            end
         end
      end
   end

   task automatic push_exp(input int base, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.row  = CNT_W'(i);
         e.data = exp_val((base + i) % NROWS);
         exp_q.push_back(e);
         addr_q.push_back((base + i) % NROWS);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, acc_rd_en, 0);
      chk({tag, "_rd_addr"}, acc_rd_addr, 0);
      chk({tag, "_clear"}, acc_clear, 0);
      chk({tag, "_valid"}, out_if.out_valid, 0);
      chk({tag, "_data"}, out_if.out_data, 0);
      chk({tag, "_row"}, out_if.out_row, 0);
   endtask

   task automatic run_drain(input int base, input int n, input bit toggle,
                            input bit timing, input string tag);
      int sc;
      bit seen;
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      rd_cnt = 0; clr_cnt = 0; clr_cyc = -100; done_cyc = -1; first_valid = -1;
      acc_cyc.delete();
      push_exp(base, n);
      base_addr = ADDR_W'(base);
      num_rows  = CNT_W'(n);
      start     = 1'b1;
      sc        = cyc;
      tick();
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (toggle) out_ready_set(pat[k % 4]);
         // a start while busy must be ignored
         start = toggle && (k == 3);
         if (start) begin
            base_addr = ADDR_W'(999);
            num_rows  = CNT_W'(5);
         end
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      out_ready_set(1'b1);
      chk({tag, "_done_seen"}, seen, 1);
      tick();
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
      chk({tag, "_addr_empty"}, addr_q.size(), 0);
      chk({tag, "_rd_count"}, rd_cnt, n);
      chk({tag, "_clear_count"}, clr_cnt, 1);
      chk({tag, "_done_after_clear"}, done_cyc - clr_cyc, 1);
      chk({tag, "_rows_out"}, acc_cyc.size(), n);
      if (timing && acc_cyc.size() == n && n > 0) begin
         chk({tag, "_latency"}, first_valid - sc, 3);
         chk({tag, "_back_to_back"}, acc_cyc[n-1] - acc_cyc[0], n - 1);
      end
   endtask

   task automatic out_ready_set(input bit v);
      out_if.out_ready = v;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
      out_if.out_ready = 1'b1;
      p_stall = 1'b0; last_data = '0;
      rd_cnt = 0; clr_cnt = 0; clr_cyc = -100; done_cyc = -1; first_valid = -1;
      tick(); tick(); tick();
      check_idle("reset");
      reset = 1'b0;
      tick();

      run_drain(0, 4, 1'b0, 1'b1, "basic");
      run_drain(1022, 3, 1'b0, 1'b1, "wrap");
      run_drain(100, 8, 1'b1, 1'b0, "stall");
      run_drain(7, 0, 1'b0, 1'b0, "zero");

      // Reset in the middle of a drain
      rd_cnt = 0; clr_cnt = 0; acc_cyc.delete();
      push_exp(0, 8);
      base_addr = '0; num_rows = CNT_W'(8); start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (acc_cyc.size() >= 2) break;
      end
      chk("midrst_two_rows", acc_cyc.size() >= 2, 1);
      reset = 1'b1;
      tick();
      check_idle("midrst");
      chk("midrst_no_clear", clr_cnt, 0);
      reset = 1'b0;
      exp_q.delete();
      addr_q.delete();
      tick();
      run_drain(20, 3, 1'b0, 1'b1, "after_rst");

      run_drain(5, 1, 1'b0, 1'b0, "relu");
      chk("relu_lane0", last_data[15:0], EXP_NEG);
      chk("relu_lane1", last_data[31:16], 16'h0007);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
